lock_chamber_ctrl: RTL and testbench

- Sequencer for a two-gate lock chamber: one outer (low-side) gate, one inner (high-side) gate, and a fill/drain pump.
- Arbitrates passage requests from both sides.
- Equalises chamber water level before opening the requested gate.
- Enforces the interlock: never both gates open, never a gate open while pumping.
- Sits above the per-gate open/close port blocks and drives their open/close commands.

---
 rtl/lock_chamber_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lock_chamber_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lock_chamber_ctrl.sv
// lock_chamber_ctrl
//   Sequencer for a two-gate lock chamber (outer/low-side gate, inner/high-side
//   gate, fill/drain pump). Latches passage requests from both sides, picks one
//   (round-robin when both are pending), equalises the chamber level and then
//   holds the requested gate open for a fixed time.
//
// Ports
//   Clock          in   system clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   ReqOuter       in   passage request, outer side (pulse or level)
//   ReqInner       in   passage request, inner side (pulse or level)
//   OuterGateOpen  out  hold outer gate open
//   InnerGateOpen  out  hold inner gate open
//   Fill           out  fill pump on
//   Drain          out  drain pump on
//   LevelHigh      out  chamber at inner (high) level
//   PendOuter      out  latched pending outer request
//   PendInner      out  latched pending inner request
//   Busy           out  sequencer not idle
//   Done           out  one-cycle pulse when a service completes
module lock_chamber_ctrl #(
    parameter int unsigned FILL_CYCLES  = 8,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned GATE_CYCLES  = 4,
    parameter int unsigned CW           = 4
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic ReqOuter,
    input  logic ReqInner,
    output logic OuterGateOpen,
    output logic InnerGateOpen,
    output logic Fill,
    output logic Drain,
    output logic LevelHigh,
    output logic PendOuter,
    output logic PendInner,
    output logic Busy,
    output logic Done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        OPEN_OUTER,
        OPEN_INNER
    } state_t;

    state_t        state;
    logic [CW-1:0] timer;
    logic          last_inner;
    logic          sel_inner;

    // Inner wins when it is the only one pending, or when both are pending and
    // the previous service was outer.
    always_comb begin
        sel_inner = PendInner & (~PendOuter | ~last_inner);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            last_inner <= 1'b0;
            LevelHigh  <= 1'b0;
            PendOuter  <= 1'b0;
            PendInner  <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (ReqOuter) PendOuter <= 1'b1;
            if (ReqInner) PendInner <= 1'b1;

            case (state)
                IDLE: begin
                    if (PendOuter || PendInner) begin
                        if (sel_inner) begin
                            if (LevelHigh) begin
                                state <= OPEN_INNER;
                                timer <= CW'(GATE_CYCLES);
                            end else begin
                                state <= FILL;
                                timer <= CW'(FILL_CYCLES);
                            end
                        end else begin
                            if (!LevelHigh) begin
                                state <= OPEN_OUTER;
                                timer <= CW'(GATE_CYCLES);
                            end else begin
                                state <= DRAIN;
                                timer <= CW'(DRAIN_CYCLES);
                            end
                        end
                    end
                end

                FILL: begin
                    if (timer == CW'(1)) begin
                        LevelHigh <= 1'b1;
                        state     <= OPEN_INNER;
                        timer     <= CW'(GATE_CYCLES);
                    end else if (timer != '0) begin
                        timer <= timer - CW'(1);
                    end
                end

                DRAIN: begin
                    if (timer == CW'(1)) begin
                        LevelHigh <= 1'b0;
                        state     <= OPEN_OUTER;
                        timer     <= CW'(GATE_CYCLES);
                    end else if (timer != '0) begin
                        timer <= timer - CW'(1);
                    end
                end

                // The clear of the served side's pend is placed after the
                // request latch above, so a same-edge request is absorbed.
                OPEN_OUTER: begin
                    if (timer == CW'(1)) begin
                        state      <= IDLE;
                        timer      <= '0;
                        Done       <= 1'b1;
                        PendOuter  <= 1'b0;
                        last_inner <= 1'b0;
                    end else if (timer != '0) begin
                        timer <= timer - CW'(1);
                    end
                end

                OPEN_INNER: begin
                    if (timer == CW'(1)) begin
                        state      <= IDLE;
                        timer      <= '0;
                        Done       <= 1'b1;
                        PendInner  <= 1'b0;
                        last_inner <= 1'b1;
                    end else if (timer != '0) begin
                        timer <= timer - CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Actuator commands decode the state register directly.
    always_comb begin
        OuterGateOpen = (state == OPEN_OUTER);
        InnerGateOpen = (state == OPEN_INNER);
        Fill          = (state == FILL);
        Drain         = (state == DRAIN);
        Busy          = (state != IDLE);
    end

    a_gates_exclusive: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(OuterGateOpen && InnerGateOpen));
    a_pumps_exclusive: assert property (@(posedge Clock) disable iff (!Reset_n)
        !(Fill && Drain));
    a_no_gate_while_pumping: assert property (@(posedge Clock) disable iff (!Reset_n)
        !((Fill || Drain) && (OuterGateOpen || InnerGateOpen)));
    a_outer_low: assert property (@(posedge Clock) disable iff (!Reset_n)
        OuterGateOpen |-> !LevelHigh);
    a_inner_high: assert property (@(posedge Clock) disable iff (!Reset_n)
        InnerGateOpen |-> LevelHigh);

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// tb_lock_chamber_ctrl
//   Directed testbench for lock_chamber_ctrl with hand-computed output vectors.
//   Output bundle bit order:
//   [8] OuterGateOpen [7] InnerGateOpen [6] Fill [5] Drain [4] LevelHigh
//   [3] PendOuter     [2] PendInner     [1] Busy [0] Done
module tb_lock_chamber_ctrl;

    logic Clock;
    logic Reset_n;
    logic ReqOuter;
    logic ReqInner;
    logic OuterGateOpen;
    logic InnerGateOpen;
    logic Fill;
    logic Drain;
    logic LevelHigh;
    logic PendOuter;
    logic PendInner;
    logic Busy;
    logic Done;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;
    int unsigned n_interlock  = 0;

    lock_chamber_ctrl #(
        .FILL_CYCLES  (8),
        .DRAIN_CYCLES (8),
        .GATE_CYCLES  (4),
        .CW           (4)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .ReqOuter      (ReqOuter),
        .ReqInner      (ReqInner),
        .OuterGateOpen (OuterGateOpen),
        .InnerGateOpen (InnerGateOpen),
        .Fill          (Fill),
        .Drain         (Drain),
        .LevelHigh     (LevelHigh),
        .PendOuter     (PendOuter),
        .PendInner     (PendInner),
        .Busy          (Busy),
        .Done          (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [8:0] outs();
        return {OuterGateOpen, InnerGateOpen, Fill, Drain, LevelHigh,
                PendOuter, PendInner, Busy, Done};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_for(input string tag, input int unsigned n, input logic [8:0] exp);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            check(tag, outs(), exp);
        end
    endtask

    // Independent interlock watcher, sampled away from the active edge.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if ((OuterGateOpen && InnerGateOpen) || (Fill && Drain) ||
                ((Fill || Drain) && (OuterGateOpen || InnerGateOpen)) ||
                (OuterGateOpen && LevelHigh) || (InnerGateOpen && !LevelHigh))
                n_interlock++;
        end
    end

    initial begin
        Reset_n  = 1'b0;
        ReqOuter = 1'b0;
        ReqInner = 1'b0;
        tick();
        tick();
        check("reset_state", outs(), 9'b000000000);
        Reset_n = 1'b1;
        expect_for("idle_after_reset", 2, 9'b000000000);

        // Outer request, level already low: gate opens directly.
        ReqOuter = 1'b1;
        tick();
        ReqOuter = 1'b0;
        check("s1_pend", outs(), 9'b000001000);
        expect_for("s1_open", 4, 9'b100001010);
        expect_for("s1_done", 1, 9'b000000001);
        expect_for("s1_idle", 1, 9'b000000000);

        // Inner request from low level: fill, then open inner.
        ReqInner = 1'b1;
        tick();
        ReqInner = 1'b0;
        check("s2_pend", outs(), 9'b000000100);
        expect_for("s2_fill", 8, 9'b001000110);
        expect_for("s2_open", 4, 9'b010010110);
        expect_for("s2_done", 1, 9'b000010001);
        expect_for("s2_idle", 1, 9'b000010000);

        // Outer request from high level: drain, then open outer.
        ReqOuter = 1'b1;
        tick();
        ReqOuter = 1'b0;
        check("s3_pend", outs(), 9'b000011000);
        expect_for("s3_drain", 8, 9'b000111010);
        expect_for("s3_open", 4, 9'b100001010);
        expect_for("s3_done", 1, 9'b000000001);
        expect_for("s3_idle", 1, 9'b000000000);

        // Both at once after an outer service: inner first, then outer.
        ReqOuter = 1'b1;
        ReqInner = 1'b1;
        tick();
        ReqOuter = 1'b0;
        ReqInner = 1'b0;
        check("s4_pend", outs(), 9'b000001100);
        expect_for("s4_fill", 8, 9'b001001110);
        expect_for("s4_open_in", 4, 9'b010011110);
        expect_for("s4_done_in", 1, 9'b000011001);
        expect_for("s4_drain", 8, 9'b000111010);
        expect_for("s4_open_out", 4, 9'b100001010);
        expect_for("s4_done_out", 1, 9'b000000001);
        expect_for("s4_idle", 1, 9'b000000000);

        // Inner re-requested during its own fill: absorbed, single service.
        ReqInner = 1'b1;
        tick();
        ReqInner = 1'b0;
        check("s5_pend", outs(), 9'b000000100);
        expect_for("s5_fill_a", 4, 9'b001000110);
        ReqInner = 1'b1;
        expect_for("s5_fill_req", 1, 9'b001000110);
        ReqInner = 1'b0;
        expect_for("s5_fill_b", 3, 9'b001000110);
        expect_for("s5_open", 4, 9'b010010110);
        expect_for("s5_done", 1, 9'b000010001);
        expect_for("s5_no_repeat", 3, 9'b000010000);

        // Both pending after an inner service: outer wins this time.
        ReqOuter = 1'b1;
        ReqInner = 1'b1;
        tick();
        ReqOuter = 1'b0;
        ReqInner = 1'b0;
        check("s6_pend", outs(), 9'b000011100);
        expect_for("s6_rr_outer", 1, 9'b000111110);

        // Reset mid-fill with the timer at 3.
        Reset_n = 1'b0;
        #1;
        check("s7_reset_async", outs(), 9'b000000000);
        tick();
        Reset_n = 1'b1;
        ReqInner = 1'b1;
        tick();
        ReqInner = 1'b0;
        check("s7_pend", outs(), 9'b000000100);
        expect_for("s7_fill", 6, 9'b001000110);
        Reset_n = 1'b0;
        #2;
        check("s7_midfill_reset", outs(), 9'b000000000);
        tick();
        Reset_n = 1'b1;
        expect_for("s7_idle_low", 3, 9'b000000000);

        check("interlock", 9'(n_interlock), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
